// File: rtl/asrv32_clint_if.sv
// Bus interface between the SoC data-bus decoder and the asrv32 core-local interruptor.
// The master drives the request fields. The slave returns a one-cycle acknowledge and the read data.
interface asrv32_clint_if;
    logic        i_stb;
    logic        i_wr_en;
    logic [4:0]  i_addr;
    logic [31:0] i_data_in;
    logic [3:0]  i_wr_mask;
    logic        o_ack;
    logic [31:0] o_data_out;

    modport master (
        output i_stb, i_wr_en, i_addr, i_data_in, i_wr_mask,
        input  o_ack, o_data_out
    );

    modport slave (
        input  i_stb, i_wr_en, i_addr, i_data_in, i_wr_mask,
        output o_ack, o_data_out
    );
endinterface

// File: rtl/asrv32_clint.sv
// asrv32 core-local interruptor: prescaled 64-bit mtime, mtimecmp, msip and external interrupt.
// Optional macro ASRV32_CLINT_EXT_SYNC_EN adds a synchronized, edge-detected sticky external IRQ.
module asrv32_clint #(
    parameter int unsigned TICK_DIV       = 100,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    asrv32_clint_if.slave        bus,
    input  logic                 i_ext_irq,
    output logic                 o_timer_interrupt,
    output logic                 o_software_interrupt,
    output logic                 o_external_interrupt,
    output logic [63:0]          o_mtime
);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_v[8*i +: 8];
            else         res[8*i +: 8] = old_v[8*i +: 8];
        end
        return res;
    endfunction

    logic [15:0] prescaler_r;
    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic        msip_r;
    logic        ack_r;
    logic [31:0] data_out_r;
    logic        timer_irq_r;

    logic [2:0]  word_s;
    logic        wr_s;
    logic        rd_s;
    logic        tick_s;
    logic        wr_msip_s;
    logic        wr_cmp_lo_s;
    logic        wr_cmp_hi_s;
    logic        wr_mt_lo_s;
    logic        wr_mt_hi_s;
    logic        wr_pend_s;
    logic [31:0] rd_data_s;
    logic [63:0] mtime_nxt_s;
    logic        ext_pend_s;
    logic        unused_s;

    assign word_s   = bus.i_addr[4:2];
    assign wr_s     = bus.i_stb & bus.i_wr_en;
    assign rd_s     = bus.i_stb & ~bus.i_wr_en;
    assign tick_s   = (prescaler_r == 16'(TICK_DIV - 1));
    assign unused_s = ^bus.i_addr[1:0];

    // Write address decode.
    always_comb begin
        wr_msip_s   = 1'b0;
        wr_pend_s   = 1'b0;
        wr_cmp_lo_s = 1'b0;
        wr_cmp_hi_s = 1'b0;
        wr_mt_lo_s  = 1'b0;
        wr_mt_hi_s  = 1'b0;
        if (wr_s) begin
            case (word_s)
                3'd0:    wr_msip_s   = 1'b1;
                3'd1:    wr_pend_s   = 1'b1;
                3'd2:    wr_cmp_lo_s = 1'b1;
                3'd3:    wr_cmp_hi_s = 1'b1;
                3'd4:    wr_mt_lo_s  = 1'b1;
                3'd5:    wr_mt_hi_s  = 1'b1;
                default: wr_msip_s   = 1'b0;
            endcase
        end else begin
            wr_msip_s = 1'b0;
        end
    end

    // Read mux, sampled from current (pre-edge) register values.
    always_comb begin
        rd_data_s = 32'd0;
        case (word_s)
            3'd0:    rd_data_s = {31'd0, msip_r};
`ifdef ASRV32_CLINT_EXT_SYNC_EN
            3'd1:    rd_data_s = {31'd0, ext_pend_s};
`endif
            3'd2:    rd_data_s = mtimecmp_r[31:0];
            3'd3:    rd_data_s = mtimecmp_r[63:32];
            3'd4:    rd_data_s = mtime_r[31:0];
            3'd5:    rd_data_s = mtime_r[63:32];
            default: rd_data_s = 32'd0;
        endcase
    end

    // A bus write to either mtime half overrides the tick increment for that cycle.
    always_comb begin
        mtime_nxt_s = mtime_r;
        if (wr_mt_lo_s) begin
            mtime_nxt_s[31:0] = merge_bytes(mtime_r[31:0], bus.i_data_in, bus.i_wr_mask);
        end else if (wr_mt_hi_s) begin
            mtime_nxt_s[63:32] = merge_bytes(mtime_r[63:32], bus.i_data_in, bus.i_wr_mask);
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

    // Bus response, timebase and timer/software interrupt registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_r <= 16'd0;
            mtime_r     <= 64'd0;
            mtimecmp_r  <= MTIMECMP_RESET;
            msip_r      <= 1'b0;
            ack_r       <= 1'b0;
            data_out_r  <= 32'd0;
            timer_irq_r <= 1'b0;
        end else begin
            ack_r       <= bus.i_stb;
            data_out_r  <= rd_s ? rd_data_s : 32'd0;
            prescaler_r <= tick_s ? 16'd0 : prescaler_r + 16'd1;
            mtime_r     <= mtime_nxt_s;
            if (wr_cmp_lo_s)
                mtimecmp_r[31:0] <= merge_bytes(mtimecmp_r[31:0], bus.i_data_in, bus.i_wr_mask);
            if (wr_cmp_hi_s)
                mtimecmp_r[63:32] <= merge_bytes(mtimecmp_r[63:32], bus.i_data_in, bus.i_wr_mask);
            if (wr_msip_s && bus.i_wr_mask[0])
                msip_r <= bus.i_data_in[0];
            timer_irq_r <= (mtime_r >= mtimecmp_r);
        end
    end

`ifdef ASRV32_CLINT_EXT_SYNC_EN
    logic sync1_r;
    logic sync2_r;
    logic sync3_r;
    logic pend_r;

    // Two-flop synchronizer, edge detect, sticky pending; a new edge beats a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            sync1_r <= i_ext_irq;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            pend_r  <= (sync2_r & ~sync3_r) |
                       (pend_r & ~(wr_pend_s & bus.i_wr_mask[0] & bus.i_data_in[0]));
        end
    end

    assign ext_pend_s = pend_r;
`else
    logic ext_irq_r;

    // Single-register level path for the external interrupt.
    always_ff @(posedge clk) begin
        if (!rst_n) ext_irq_r <= 1'b0;
        else        ext_irq_r <= i_ext_irq;
    end

    assign ext_pend_s = ext_irq_r;
`endif

    assign bus.o_ack            = ack_r;
    assign bus.o_data_out       = data_out_r;
    assign o_timer_interrupt    = timer_irq_r;
    assign o_software_interrupt = msip_r;
    assign o_external_interrupt = ext_pend_s;
    assign o_mtime              = mtime_r;

endmodule

// File: tb/tb_asrv32_clint.sv
// Directed self-checking bench for asrv32_clint (TICK_DIV=100).
module tb_asrv32_clint;
    logic        clk;
    logic        rst_n;
    logic        i_ext_irq;
    logic        o_timer_interrupt;
    logic        o_software_interrupt;
    logic        o_external_interrupt;
    logic [63:0] o_mtime;
    int          checks;
    int          failures;

    asrv32_clint_if bus ();

    asrv32_clint #(.TICK_DIV(100), .MTIMECMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus                  (bus.slave),
        .i_ext_irq            (i_ext_irq),
        .o_timer_interrupt    (o_timer_interrupt),
        .o_software_interrupt (o_software_interrupt),
        .o_external_interrupt (o_external_interrupt),
        .o_mtime              (o_mtime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic xfer(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, output logic [31:0] rdata, output logic acked);
        @(negedge clk);
        bus.i_stb = 1'b1; bus.i_wr_en = we; bus.i_addr = addr;
        bus.i_data_in = wdata; bus.i_wr_mask = mask;
        @(posedge clk);
        #1;
        acked = bus.o_ack; rdata = bus.o_data_out;
        bus.i_stb = 1'b0; bus.i_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_stb = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic ak;
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (bus.o_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.o_ack); end
        checks++; if (bus.o_data_out !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.o_data_out); end
        checks++; if ({o_timer_interrupt, o_software_interrupt, o_external_interrupt} !== 3'b000) begin
            failures++; $display("FAIL reset_irqs got=%b exp=000", {o_timer_interrupt, o_software_interrupt, o_external_interrupt}); end
        checks++; if (o_mtime !== 64'd0) begin failures++; $display("FAIL reset_mtime got=%h exp=0", o_mtime); end
        @(negedge clk); rst_n = 1'b1;
        xfer(1'b0, 5'h0C, 32'd0, 4'h0, rd, ak);
        checks++; if (ak !== 1'b1 || rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp_hi got=%h ack=%b exp=ffffffff", rd, ak); end
        xfer(1'b0, 5'h08, 32'd0, 4'h0, rd, ak);
        checks++; if (ak !== 1'b1 || rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp_lo got=%h ack=%b exp=ffffffff", rd, ak); end
        checks++; if (o_timer_interrupt !== 1'b0) begin failures++; $display("FAIL reset_timer got=%b exp=0", o_timer_interrupt); end
        xfer(1'b0, 5'h10, 32'd0, 4'h0, rd, ak);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_mtime_rd got=%h exp=0", rd); end
        // A strobe whose edge also sees reset must not be acknowledged.
        @(negedge clk);
        bus.i_stb = 1'b1; bus.i_wr_en = 1'b0; bus.i_addr = 5'h0C; rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.o_ack !== 1'b0) begin failures++; $display("FAIL reset_mid_ack got=%b exp=0", bus.o_ack); end
        bus.i_stb = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_tick_rate();
        logic [31:0] rd; logic ak;
        do_reset();
        repeat (1000) @(posedge clk);
        #1;
        checks++; if (o_mtime !== 64'd10) begin failures++; $display("FAIL tick_mtime got=%0d exp=10", o_mtime); end
        xfer(1'b0, 5'h10, 32'd0, 4'h0, rd, ak);
        checks++; if (rd !== 32'd10) begin failures++; $display("FAIL tick_read got=%0d exp=10", rd); end
    endtask

    task automatic test_timer_irq();
        logic [31:0] rd; logic ak; bit found;
        do_reset();
        xfer(1'b1, 5'h0C, 32'd0, 4'hF, rd, ak);
        xfer(1'b1, 5'h08, 32'd15, 4'hF, rd, ak);
        checks++; if (ak !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL wr_ack got=%h ack=%b exp=0/1", rd, ak); end
        checks++; if (o_timer_interrupt !== 1'b0) begin failures++; $display("FAIL timer_early got=%b exp=0", o_timer_interrupt); end
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk); #1;
            if (o_mtime == 64'd15) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL timer_wait got=%0d exp=15", o_mtime); end
        checks++; if (o_timer_interrupt !== 1'b0) begin failures++; $display("FAIL timer_lat got=%b exp=0", o_timer_interrupt); end
        @(posedge clk); #1;
        checks++; if (o_timer_interrupt !== 1'b1) begin failures++; $display("FAIL timer_rise got=%b exp=1", o_timer_interrupt); end
        xfer(1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF, rd, ak);
        checks++; if (o_timer_interrupt !== 1'b1) begin failures++; $display("FAIL timer_hold got=%b exp=1", o_timer_interrupt); end
        @(posedge clk); #1;
        checks++; if (o_timer_interrupt !== 1'b0) begin failures++; $display("FAIL timer_fall got=%b exp=0", o_timer_interrupt); end
    endtask

    task automatic test_software_irq();
        logic [31:0] rd; logic ak;
        xfer(1'b1, 5'h00, 32'h1, 4'b0001, rd, ak);
        checks++; if (o_software_interrupt !== 1'b1) begin failures++; $display("FAIL msip_set got=%b exp=1", o_software_interrupt); end
        xfer(1'b0, 5'h00, 32'd0, 4'h0, rd, ak);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL msip_read got=%h exp=1", rd); end
        xfer(1'b1, 5'h00, 32'h0, 4'b0001, rd, ak);
        checks++; if (o_software_interrupt !== 1'b0) begin failures++; $display("FAIL msip_clr got=%b exp=0", o_software_interrupt); end
        xfer(1'b1, 5'h00, 32'h1, 4'b0000, rd, ak);
        checks++; if (o_software_interrupt !== 1'b0) begin failures++; $display("FAIL msip_nomask got=%b exp=0", o_software_interrupt); end
        xfer(1'b1, 5'h00, 32'hFFFF_FFFF, 4'hF, rd, ak);
        xfer(1'b0, 5'h00, 32'd0, 4'h0, rd, ak);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL msip_bits got=%h exp=1", rd); end
        xfer(1'b1, 5'h00, 32'h0, 4'hF, rd, ak);
    endtask

    task automatic test_carry_collision();
        logic [31:0] rd; logic ak; bit found;
        do_reset();
        xfer(1'b1, 5'h14, 32'd0, 4'hF, rd, ak);
        xfer(1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF, rd, ak);
        checks++; if (o_mtime !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL mtime_wr got=%h exp=ffffffff", o_mtime); end
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #1;
            if (o_mtime != 64'h0000_0000_FFFF_FFFF) found = 1'b1;
        end
        checks++; if (o_mtime !== 64'h0000_0001_0000_0000) begin failures++; $display("FAIL carry got=%h exp=100000000", o_mtime); end
        // Next tick is 100 edges after the one just seen; land the write on it.
        repeat (99) @(posedge clk);
        xfer(1'b1, 5'h10, 32'd5, 4'hF, rd, ak);
        checks++; if (o_mtime !== 64'h0000_0001_0000_0005) begin failures++; $display("FAIL collision got=%h exp=100000005", o_mtime); end
        repeat (99) @(posedge clk);
        #1;
        checks++; if (o_mtime !== 64'h0000_0001_0000_0005) begin failures++; $display("FAIL coll_hold got=%h exp=100000005", o_mtime); end
        @(posedge clk); #1;
        checks++; if (o_mtime !== 64'h0000_0001_0000_0006) begin failures++; $display("FAIL coll_wrap got=%h exp=100000006", o_mtime); end
        xfer(1'b0, 5'h14, 32'd0, 4'h0, rd, ak);
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL mtime_hi_rd got=%h exp=1", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic ak;
        do_reset();
        xfer(1'b1, 5'h08, 32'h1234_5678, 4'b0011, rd, ak);
        @(negedge clk);
        bus.i_stb = 1'b1; bus.i_wr_en = 1'b0; bus.i_addr = 5'h0C;
        @(posedge clk); #1;
        checks++; if (bus.o_ack !== 1'b1 || bus.o_data_out !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL b2b_first got=%h ack=%b exp=ffffffff", bus.o_data_out, bus.o_ack); end
        bus.i_addr = 5'h08;
        @(posedge clk); #1;
        checks++; if (bus.o_ack !== 1'b1 || bus.o_data_out !== 32'hFFFF_5678) begin
            failures++; $display("FAIL b2b_second got=%h ack=%b exp=ffff5678", bus.o_data_out, bus.o_ack); end
        bus.i_addr = 5'h18;
        @(posedge clk); #1;
        checks++; if (bus.o_ack !== 1'b1 || bus.o_data_out !== 32'd0) begin
            failures++; $display("FAIL b2b_unmapped got=%h ack=%b exp=0", bus.o_data_out, bus.o_ack); end
        bus.i_stb = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.o_ack !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", bus.o_ack); end
        xfer(1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, rd, ak);
        checks++; if (ak !== 1'b1) begin failures++; $display("FAIL unmapped_wr_ack got=%b exp=1", ak); end
    endtask

    task automatic test_external_irq();
        logic [31:0] rd; logic ak;
        do_reset();
        @(negedge clk); i_ext_irq = 1'b1;
`ifdef ASRV32_CLINT_EXT_SYNC_EN
        @(posedge clk); #1;
        checks++; if (o_external_interrupt !== 1'b0) begin failures++; $display("FAIL ext_c1 got=%b exp=0", o_external_interrupt); end
        @(negedge clk); @(posedge clk); #1;
        checks++; if (o_external_interrupt !== 1'b0) begin failures++; $display("FAIL ext_c2 got=%b exp=0", o_external_interrupt); end
        @(negedge clk); i_ext_irq = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_external_interrupt !== 1'b1) begin failures++; $display("FAIL ext_c3 got=%b exp=1", o_external_interrupt); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (o_external_interrupt !== 1'b1) begin failures++; $display("FAIL ext_sticky got=%b exp=1", o_external_interrupt); end
        xfer(1'b0, 5'h04, 32'd0, 4'h0, rd, ak);
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL ext_pend_rd got=%h exp=1", rd); end
        xfer(1'b1, 5'h04, 32'd1, 4'hF, rd, ak);
        checks++; if (o_external_interrupt !== 1'b0) begin failures++; $display("FAIL ext_clear got=%b exp=0", o_external_interrupt); end
`else
        #1;
        checks++; if (o_external_interrupt !== 1'b0) begin failures++; $display("FAIL ext_pre got=%b exp=0", o_external_interrupt); end
        @(posedge clk); #1;
        checks++; if (o_external_interrupt !== 1'b1) begin failures++; $display("FAIL ext_c1 got=%b exp=1", o_external_interrupt); end
        @(negedge clk); @(posedge clk); #1;
        checks++; if (o_external_interrupt !== 1'b1) begin failures++; $display("FAIL ext_c2 got=%b exp=1", o_external_interrupt); end
        @(negedge clk); i_ext_irq = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_external_interrupt !== 1'b0) begin failures++; $display("FAIL ext_fall got=%b exp=0", o_external_interrupt); end
        xfer(1'b0, 5'h04, 32'd0, 4'h0, rd, ak);
        checks++; if (rd !== 32'd0 || ak !== 1'b1) begin failures++; $display("FAIL ext_off04 got=%h ack=%b exp=0", rd, ak); end
`endif
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; i_ext_irq = 1'b0;
        bus.i_stb = 1'b0; bus.i_wr_en = 1'b0; bus.i_addr = 5'd0;
        bus.i_data_in = 32'd0; bus.i_wr_mask = 4'd0;
        test_reset();
        test_tick_rate();
        test_timer_irq();
        test_software_irq();
        test_carry_collision();
        test_back_to_back();
        test_external_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
